// File: rtl/load_register_pkg.sv
// Shared defaults for the load_register storage element.
package load_register_pkg;

    // Default data width: a single-bit register.
    localparam int DefaultWidth = 1;

    // Every bit of the default reset value; the full vector is this bit replicated.
    localparam logic DefaultRstBit = 1'b0;

endpackage

// File: rtl/load_register_dff_en.sv
// Single-bit flop with synchronous active-high reset, reset-value input and load enable.
module load_register_dff_en (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    // Reset beats enable; with neither asserted the bit holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= rst_val_i;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/load_register.sv
// N-bit storage register with synchronous load enable and synchronous reset to RST_VAL.
// q comes straight from flops; there is no combinational path from any input to q.
module load_register
    import load_register_pkg::*;
#(
    parameter int           N       = DefaultWidth,
    parameter logic [N-1:0] RST_VAL = {N{DefaultRstBit}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic [N-1:0] q
);

    // Reject degenerate widths at elaboration.
    if (N < 1) begin : g_bad_width
        $error("load_register: N must be at least 1");
    end

    // One enabled flop per bit; all bits share load and rst, so the word updates as a unit.
    for (genvar i = 0; i < N; i++) begin : g_bit
        load_register_dff_en u_dff_en (
            .clk_i     (clk),
            .rst_i     (rst),
            .rst_val_i (RST_VAL[i]),
            .en_i      (load),
            .d_i       (din[i]),
            .q_o       (q[i])
        );
    end

endmodule

// File: tb/tb_load_register.sv
// Directed bench for load_register: a 1-bit default instance and an 8-bit instance
// with a non-zero reset value.
module tb_load_register;

    logic       clk;
    logic       rst1, load1;
    logic       din1, din_tog, din_dir, tog_en;
    logic       q1;
    logic       rst8, load8;
    logic [7:0] din8, q8;

    int n_checks = 0;
    int n_fail   = 0;

    load_register u_dut1 (
        .clk  (clk),
        .rst  (rst1),
        .load (load1),
        .din  (din1),
        .q    (q1)
    );

    load_register #(
        .N       (8),
        .RST_VAL (8'h3C)
    ) u_dut8 (
        .clk  (clk),
        .rst  (rst8),
        .load (load8),
        .din  (din8),
        .q    (q8)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // din toggles every 25 ns at 28, 53, 78, ... which never lands on a rising edge.
    initial begin
        din_tog = 1'b0;
        #3;
        forever begin
            #25;
            din_tog = ~din_tog;
        end
    end

    assign din1 = tog_en ? din_tog : din_dir;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #5;
    endtask

    initial begin
        logic exp1;

        rst1    = 1'b1;
        load1   = 1'b0;
        din_dir = 1'b0;
        tog_en  = 1'b1;
        rst8    = 1'b1;
        load8   = 1'b0;
        din8    = 8'h00;

        // Reset for two edges with din toggling.
        step();
        check("rst_edge1", {7'b0, q1}, 8'h00);
        check("rst8_edge1", q8, 8'h3C);
        step();
        check("rst_edge2", {7'b0, q1}, 8'h00);
        rst1 = 1'b0;

        // Hold: load low, din toggling, q must stay at zero.
        for (int i = 0; i < 100; i++) begin
            step();
            check("hold", {7'b0, q1}, 8'h00);
        end

        // Load every edge: q follows din sampled at that edge.
        load1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            exp1 = din1;
            #5;
            check("load_follow", {7'b0, q1}, {7'b0, exp1});
        end

        // Priority: reset beats load.
        tog_en  = 1'b0;
        din_dir = 1'b1;
        rst1    = 1'b1;
        step();
        check("rst_over_load", {7'b0, q1}, 8'h00);
        rst1 = 1'b0;
        step();
        check("load_after_rst", {7'b0, q1}, 8'h01);

        // 8-bit instance with custom reset value.
        check("rst8_held", q8, 8'h3C);
        rst8  = 1'b0;
        step();
        check("rst8_release_hold", q8, 8'h3C);
        load8 = 1'b1;
        din8  = 8'hA5;
        step();
        check("load8_a5", q8, 8'hA5);
        load8 = 1'b0;
        din8  = 8'hFF;
        step();
        check("hold8_a", q8, 8'hA5);
        step();
        check("hold8_b", q8, 8'hA5);
        rst8  = 1'b1;
        load8 = 1'b1;
        step();
        check("rst8_mid", q8, 8'h3C);
        rst8 = 1'b0;
        step();
        check("load8_ff", q8, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
